// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX pipeline register for the ALU path. Decodes the MIPS opcode/funct
//   into the 4-bit ALUControl code, selects and extends the two ALU operands
//   (register, sign/zero-extended immediate or shift amount) and registers
//   the result into EX with stall, flush and a valid bit.
//   Only DATA_W = 32 and REG_AW = 5 are supported; the instruction fields are
//   fixed-width and the extensions assume a 32-bit datapath.

module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_ctrl,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [REG_AW-1:0] ex_wr_reg,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  // ---------------------------------------------------------------------------
  // ALU control encoding, as understood by the downstream ALU
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SRA = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101
  } alu_ctrl_e;

  // Where ALU data1 comes from
  typedef enum logic [2:0] {
    SRC1_ZERO,      // illegal instructions present zero operands
    SRC1_RS,        // rs register value
    SRC1_SHAMT,     // instruction shamt field, zero-extended
    SRC1_RS_LOW5,   // rs[4:0]; the ALU shifts by the whole data1 value
    SRC1_LUI_SHIFT  // constant 16, so that lui becomes imm << 16
  } src1_e;

  // Where ALU data2 comes from
  typedef enum logic [1:0] {
    SRC2_ZERO,
    SRC2_RT,        // rt register value
    SRC2_SIMM,      // sign-extended immediate
    SRC2_ZIMM       // zero-extended immediate
  } src2_e;

  // Which instruction field names the destination register
  typedef enum logic [1:0] {
    DST_NONE,       // no write-back; wr_reg reported as 0
    DST_RD,
    DST_RT
  } dst_e;

  // Everything the decoder decides about one instruction
  typedef struct packed {
    alu_ctrl_e alu_ctrl;
    src1_e     src1;
    src2_e     src2;
    dst_e      dst;
    logic      reg_write;
    logic      illegal;
  } dec_t;

  // ---------------------------------------------------------------------------
  // Opcode and funct values
  // ---------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Decode of anything not recognised: ADD of two zeros, no write-back
  localparam dec_t DEC_ILLEGAL = '{
    alu_ctrl:  ALU_ADD,
    src1:      SRC1_ZERO,
    src2:      SRC2_ZERO,
    dst:       DST_NONE,
    reg_write: 1'b0,
    illegal:   1'b1
  };

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [REG_AW-1:0] rt_idx;
  logic [REG_AW-1:0] rd_idx;
  logic [15:0]       imm;

  assign opcode = id_instr[31:26];
  assign rt_idx = id_instr[20:16];
  assign rd_idx = id_instr[15:11];
  assign shamt  = id_instr[10:6];
  assign funct  = id_instr[5:0];
  assign imm    = id_instr[15:0];

  // The rs index is not needed here: its value arrives already forwarded.
  logic unused_rs_field;
  assign unused_rs_field = ^id_instr[25:21];

  // R-type entry: destination rd, write-back, data2 = rt
  function automatic dec_t r_op(input alu_ctrl_e ctrl, input src1_e src1);
    return '{alu_ctrl: ctrl, src1: src1, src2: SRC2_RT, dst: DST_RD,
             reg_write: 1'b1, illegal: 1'b0};
  endfunction

  // I-type entry: data1 = rs, destination rt, write-back
  function automatic dec_t i_op(input alu_ctrl_e ctrl, input src2_e src2);
    return '{alu_ctrl: ctrl, src1: SRC1_RS, src2: src2, dst: DST_RT,
             reg_write: 1'b1, illegal: 1'b0};
  endfunction

  // Entry for instructions that use the ALU but never write a register
  function automatic dec_t no_wb_op(input alu_ctrl_e ctrl, input src2_e src2);
    return '{alu_ctrl: ctrl, src1: SRC1_RS, src2: src2, dst: DST_NONE,
             reg_write: 1'b0, illegal: 1'b0};
  endfunction

  dec_t dec;

  // Opcode/funct decode into ALU control, operand sources and destination
  always_comb begin
    // NOTE: assigning a full default before the case keeps every path driven,
    // so no latch is inferred for fields a branch does not mention.
    dec = DEC_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: dec = r_op(ALU_ADD, SRC1_RS);
          FN_SUB, FN_SUBU: dec = r_op(ALU_SUB, SRC1_RS);
          FN_AND:          dec = r_op(ALU_AND, SRC1_RS);
          FN_OR:           dec = r_op(ALU_OR,  SRC1_RS);
          FN_XOR:          dec = r_op(ALU_XOR, SRC1_RS);
          FN_NOR:          dec = r_op(ALU_NOR, SRC1_RS);
          FN_SLT:          dec = r_op(ALU_SLT, SRC1_RS);
          FN_SLL:          dec = r_op(ALU_SLL, SRC1_SHAMT);
          FN_SRL:          dec = r_op(ALU_SRL, SRC1_SHAMT);
          FN_SRA:          dec = r_op(ALU_SRA, SRC1_SHAMT);
          FN_SLLV:         dec = r_op(ALU_SLL, SRC1_RS_LOW5);
          FN_SRLV:         dec = r_op(ALU_SRL, SRC1_RS_LOW5);
          FN_SRAV:         dec = r_op(ALU_SRA, SRC1_RS_LOW5);
          FN_JR:           dec = no_wb_op(ALU_ADD, SRC2_RT);
          default:         dec = DEC_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU: dec = i_op(ALU_ADD, SRC2_SIMM);
      OP_SLTI:           dec = i_op(ALU_SLT, SRC2_SIMM);
      OP_ANDI:           dec = i_op(ALU_AND, SRC2_ZIMM);
      OP_ORI:            dec = i_op(ALU_OR,  SRC2_ZIMM);
      OP_XORI:           dec = i_op(ALU_XOR, SRC2_ZIMM);
      OP_LW:             dec = i_op(ALU_ADD, SRC2_SIMM);
      OP_LUI: begin
        dec      = i_op(ALU_SLL, SRC2_ZIMM);
        dec.src1 = SRC1_LUI_SHIFT;
      end
      OP_SW:             dec = no_wb_op(ALU_ADD, SRC2_SIMM);
      OP_BEQ, OP_BNE:    dec = no_wb_op(ALU_SUB, SRC2_RT);
      default:           dec = DEC_ILLEGAL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand and destination selection
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] simm;
  logic [DATA_W-1:0] zimm;
  logic [DATA_W-1:0] data1_d;
  logic [DATA_W-1:0] data2_d;
  logic [REG_AW-1:0] wr_reg_d;

  assign simm = {{(DATA_W-16){imm[15]}}, imm};
  assign zimm = {{(DATA_W-16){1'b0}}, imm};

  // data1 mux: register, shift amount, masked rs or the lui shift constant
  always_comb begin
    case (dec.src1)
      SRC1_RS:        data1_d = id_rs_data;
      SRC1_SHAMT:     data1_d = {{(DATA_W-5){1'b0}}, shamt};
      SRC1_RS_LOW5:   data1_d = {{(DATA_W-5){1'b0}}, id_rs_data[4:0]};
      SRC1_LUI_SHIFT: data1_d = DATA_W'(16);
      default:        data1_d = '0;
    endcase
  end

  // data2 mux: register or extended immediate
  always_comb begin
    case (dec.src2)
      SRC2_RT:   data2_d = id_rt_data;
      SRC2_SIMM: data2_d = simm;
      SRC2_ZIMM: data2_d = zimm;
      default:   data2_d = '0;
    endcase
  end

  // Destination register index; 0 when the instruction does not write back
  always_comb begin
    case (dec.dst)
      DST_RD:  wr_reg_d = rd_idx;
      DST_RT:  wr_reg_d = rt_idx;
      default: wr_reg_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EX register: reset and flush clear, stall holds, otherwise load the decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every EX register samples the
    // pre-edge values, independent of statement order.
    if (reset || flush) begin
      ex_valid     <= 1'b0;
      ex_alu_ctrl  <= ALU_AND;
      ex_data1     <= '0;
      ex_data2     <= '0;
      ex_wr_reg    <= '0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_alu_ctrl  <= dec.alu_ctrl;
      ex_data1     <= data1_d;
      ex_data2     <= data2_d;
      ex_wr_reg    <= wr_reg_d;
      // A bubble in ID must never write back or raise a trap.
      ex_reg_write <= id_valid & dec.reg_write;
      ex_illegal   <= id_valid & dec.illegal;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Directed scenarios followed by randomized instruction streams, all checked
//   against an instruction-level reference model of the ID/EX stage.

module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_data1;
  logic [31:0] ex_data2;
  logic [4:0]  ex_wr_reg;
  logic        ex_reg_write;
  logic        ex_illegal;

  alu_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_data1     (ex_data1),
    .ex_data2     (ex_data2),
    .ex_wr_reg    (ex_wr_reg),
    .ex_reg_write (ex_reg_write),
    .ex_illegal   (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected EX contents; 'known' is cleared when the slot was loaded from a
  // bubble, whose operand fields are unspecified.
  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  wr;
    logic        rw;
    logic        ill;
    logic        known;
  } exp_t;

  localparam exp_t EXP_CLEAR = '{valid: 1'b0, ctrl: 4'h0, d1: 32'h0, d2: 32'h0,
                                 wr: 5'h0, rw: 1'b0, ill: 1'b0, known: 1'b1};

  localparam logic [5:0] R_FUNCTS [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                           6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03,
                                           6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] I_OPS [11] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                                        6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
  localparam logic [31:0] EDGE_DATA [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                                            32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0024};

  exp_t model;
  int   n_vec;
  int   n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ctrl, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [4:0] wr, input logic rw);
    return '{valid: 1'b1, ctrl: ctrl, d1: d1, d2: d2, wr: wr, rw: rw, ill: 1'b0, known: 1'b1};
  endfunction

  // What the ALU should be told for instruction w with operands a (rs) and b (rt)
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] se;
    logic [31:0] ze;
    logic [31:0] sh;
    logic [31:0] amt;
    logic [4:0]  rt;
    logic [4:0]  rd;
    exp_t        e;
    se  = 32'($signed(w[15:0]));
    ze  = 32'(w[15:0]);
    sh  = 32'(w[10:6]);
    amt = a % 32;
    rt  = w[20:16];
    rd  = w[15:11];
    e   = '{valid: 1'b1, ctrl: 4'b0010, d1: 32'h0, d2: 32'h0, wr: 5'h0,
            rw: 1'b0, ill: 1'b1, known: 1'b1};
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20, 6'h21: e = mk(4'b0010, a, b, rd, 1'b1);
        6'h22, 6'h23: e = mk(4'b0110, a, b, rd, 1'b1);
        6'h24:        e = mk(4'b0000, a, b, rd, 1'b1);
        6'h25:        e = mk(4'b0001, a, b, rd, 1'b1);
        6'h26:        e = mk(4'b1101, a, b, rd, 1'b1);
        6'h27:        e = mk(4'b1100, a, b, rd, 1'b1);
        6'h2A:        e = mk(4'b0111, a, b, rd, 1'b1);
        6'h00:        e = mk(4'b0100, sh, b, rd, 1'b1);
        6'h02:        e = mk(4'b0101, sh, b, rd, 1'b1);
        6'h03:        e = mk(4'b0011, sh, b, rd, 1'b1);
        6'h04:        e = mk(4'b0100, amt, b, rd, 1'b1);
        6'h06:        e = mk(4'b0101, amt, b, rd, 1'b1);
        6'h07:        e = mk(4'b0011, amt, b, rd, 1'b1);
        6'h08:        e = mk(4'b0010, a, b, 5'd0, 1'b0);
        default:      ;
      endcase
    end else begin
      case (w[31:26])
        6'h08, 6'h09: e = mk(4'b0010, a, se, rt, 1'b1);
        6'h0A:        e = mk(4'b0111, a, se, rt, 1'b1);
        6'h0C:        e = mk(4'b0000, a, ze, rt, 1'b1);
        6'h0D:        e = mk(4'b0001, a, ze, rt, 1'b1);
        6'h0E:        e = mk(4'b1101, a, ze, rt, 1'b1);
        6'h0F:        e = mk(4'b0100, 32'd16, ze, rt, 1'b1);
        6'h23:        e = mk(4'b0010, a, se, rt, 1'b1);
        6'h2B:        e = mk(4'b0010, a, se, 5'd0, 1'b0);
        6'h04, 6'h05: e = mk(4'b0110, a, b, 5'd0, 1'b0);
        default:      ;
      endcase
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] a,
                       input logic [31:0] b, input logic st, input logic fl, input logic rst);
    id_valid   = v;
    id_instr   = w;
    id_rs_data = a;
    id_rt_data = b;
    stall      = st;
    flush      = fl;
    reset      = rst;
  endtask

  // One clock: advance the model from the applied inputs, then compare
  task automatic tick();
    exp_t nxt;
    if (reset || flush) begin
      nxt = EXP_CLEAR;
    end else if (stall) begin
      nxt = model;
    end else if (id_valid) begin
      nxt = ref_decode(id_instr, id_rs_data, id_rt_data);
    end else begin
      nxt       = EXP_CLEAR;
      nxt.known = 1'b0;
    end
    @(posedge clk);
    #1;
    model = nxt;
    check("valid", 32'(ex_valid), 32'(model.valid));
    check("reg_write", 32'(ex_reg_write), 32'(model.rw));
    check("illegal", 32'(ex_illegal), 32'(model.ill));
    if (model.known) begin
      check("alu_ctrl", 32'(ex_alu_ctrl), 32'(model.ctrl));
      check("data1", ex_data1, model.d1);
      check("data2", ex_data2, model.d2);
      check("wr_reg", 32'(ex_wr_reg), 32'(model.wr));
    end
  endtask

  function automatic logic [31:0] rand_data();
    if ($urandom_range(0, 3) == 0) return EDGE_DATA[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 99);
    if (k < 45) begin
      w[31:26] = 6'h00;
      w[5:0]   = R_FUNCTS[$urandom_range(0, 15)];
    end else if (k < 88) begin
      w[31:26] = I_OPS[$urandom_range(0, 10)];
    end else if (k < 93) begin
      w = 32'h0;
    end
    return w;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    model = EXP_CLEAR;

    // Reset state
    drive(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_ctrl", 32'(ex_alu_ctrl), 32'h0);

    // add $3,$1,$2
    drive(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    tick();
    check("add_d1", ex_data1, 32'd5);
    check("add_d2", ex_data2, 32'd7);
    check("add_wr", 32'(ex_wr_reg), 32'd3);

    // addi with -1, then andi with 0xFFFF
    drive(1'b1, 32'h2024_FFFF, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("addi_d2", ex_data2, 32'hFFFF_FFFF);
    drive(1'b1, 32'h3024_FFFF, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("andi_d2", ex_data2, 32'h0000_FFFF);
    check("andi_ctrl", 32'(ex_alu_ctrl), 32'h0);

    // sra by 4, then srav with rs=0x24 masked to 4
    drive(1'b1, 32'h0003_1103, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("sra_ctrl", 32'(ex_alu_ctrl), 32'h3);
    check("sra_d1", ex_data1, 32'd4);
    drive(1'b1, 32'h0023_1007, 32'h0000_0024, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("srav_d1", ex_data1, 32'd4);

    // lui $5,0x1234
    drive(1'b1, 32'h3C05_1234, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("lui_ctrl", 32'(ex_alu_ctrl), 32'h4);
    check("lui_d1", ex_data1, 32'd16);
    check("lui_d2", ex_data2, 32'h1234);

    // add, then stall three cycles with ID changing, then flush during stall
    drive(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_instr(), rand_data(), rand_data(), 1'b1, 1'b0, 1'b0);
      tick();
      check("stall_d1", ex_data1, 32'd5);
    end
    drive(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    tick();
    check("flush_valid", 32'(ex_valid), 32'h0);

    // Illegal opcode, then reset during a stall
    drive(1'b1, 32'hFC00_0000, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    tick();
    check("illegal_flag", 32'(ex_illegal), 32'h1);
    check("illegal_ctrl", 32'(ex_alu_ctrl), 32'h2);
    drive(1'b1, 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
    tick();
    check("rst_stall_valid", 32'(ex_valid), 32'h0);

    // NOP decodes as sll $0,$0,0 with write-back
    drive(1'b1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tick();
    check("nop_rw", 32'(ex_reg_write), 32'h1);

    // Randomized streams with bubbles, stalls, flushes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 85, rand_instr(), rand_data(), rand_data(),
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 2);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
